ahb_bus_monitor: RTL and testbench

//  Passive, synthesizable AHB protocol monitor and statistics block; sits on the ahb_m/ahb_s bus, drives nothing onto it.

---
 rtl/ahb_mon_pkg.sv | 79 +++++++
 rtl/ahb_mon_fifo.sv | 46 ++++
 rtl/ahb_bus_monitor.sv | 270 +++++++++++++++++++++++++++
 tb/tb_ahb_bus_monitor.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_mon_pkg.sv
// rtl/ahb_mon_pkg.sv - shared AHB types, violation codes and burst address helpers for the bus monitor
package ahb_mon_pkg;

    // Widest address handled by the helper functions; callers cast to their own width.
    localparam int MAX_AW = 64;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [2:0] {
        HSIZE_8    = 3'd0,
        HSIZE_16   = 3'd1,
        HSIZE_32   = 3'd2,
        HSIZE_64   = 3'd3,
        HSIZE_128  = 3'd4,
        HSIZE_256  = 3'd5,
        HSIZE_512  = 3'd6,
        HSIZE_1024 = 3'd7
    } hsize_e;

    typedef enum logic [3:0] {
        ERR_NONE          = 4'd0,
        ERR_OUTSIDE_BURST = 4'd1,
        ERR_SEQ_ADDR      = 4'd2,
        ERR_CTRL_CHANGE   = 4'd3,
        ERR_EARLY_END     = 4'd4,
        ERR_PAST_LAST     = 4'd5,
        ERR_SIZE          = 4'd6,
        ERR_ALIGN         = 4'd7,
        ERR_CROSS_1KB     = 4'd8,
        ERR_STALL_CHANGE  = 4'd9
    } err_code_e;

    // Beat count of a burst type; 0 means undefined length (INCR).
    function automatic logic [4:0] burst_beats(input logic [2:0] burst);
        case (burst)
            HBURST_SINGLE:               return 5'd1;
            HBURST_WRAP4, HBURST_INCR4:  return 5'd4;
            HBURST_WRAP8, HBURST_INCR8:  return 5'd8;
            HBURST_WRAP16, HBURST_INCR16: return 5'd16;
            default:                     return 5'd0;
        endcase
    endfunction

    // WRAP bursts are the even, non-SINGLE encodings.
    function automatic logic burst_is_wrap(input logic [2:0] burst);
        return (burst[0] == 1'b0) && (burst != HBURST_SINGLE);
    endfunction

    // Address of the beat that follows addr within the burst.
    function automatic logic [MAX_AW-1:0] next_addr(input logic [MAX_AW-1:0] addr,
                                                    input logic [2:0]        size,
                                                    input logic [2:0]        burst);
        logic [MAX_AW-1:0] incr;
        logic [MAX_AW-1:0] mask;
        incr = MAX_AW'(1) << size;
        mask = (MAX_AW'(burst_beats(burst)) << size) - MAX_AW'(1);
        if (burst_is_wrap(burst)) begin
            return (addr & ~mask) | ((addr + incr) & mask);
        end
        return addr + incr;
    endfunction

endpackage

// File: rtl/ahb_mon_fifo.sv
// rtl/ahb_mon_fifo.sv - synchronous trace FIFO with full/empty flags, write accepted when full if a pop frees a slot
module ahb_mon_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 44
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW:0]      r_wr_ptr;
    logic [PW:0]      r_rd_ptr;
    logic             w_wr_en;
    logic             w_rd_en;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign w_rd_en = i_pop && !o_empty;
    assign w_wr_en = i_push && (!o_full || w_rd_en);
    assign o_data  = r_mem[r_rd_ptr[PW-1:0]];

    // Pointer bookkeeping; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[PW-1:0]] <= i_data;
    end

endmodule

// File: rtl/ahb_bus_monitor.sv
// rtl/ahb_bus_monitor.sv - passive AHB burst tracker, rule checker and statistics block; AHB_MON_TRACE_EN adds the trace FIFO
module ahb_bus_monitor
    import ahb_mon_pkg::*;
#(
    parameter int AHB_DATA_WIDTH    = 64,
    parameter int AHB_ADDRESS_WIDTH = 32,
    parameter int CNT_W             = 32,
    parameter int TRC_DEPTH         = 16
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic [AHB_ADDRESS_WIDTH-1:0]  HADDR,
    input  logic [1:0]                    HTRANS,
    input  logic                          HWRITE,
    input  logic [2:0]                    HSIZE,
    input  logic [2:0]                    HBURST,
    input  logic                          HREADY,
    input  logic                          HRESP,
    output logic                          err_valid,
    output logic [3:0]                    err_code,
    output logic [AHB_ADDRESS_WIDTH-1:0]  err_addr,
    output logic [CNT_W-1:0]              cnt_nonseq,
    output logic [CNT_W-1:0]              cnt_seq,
    output logic [CNT_W-1:0]              cnt_busy,
    output logic [CNT_W-1:0]              cnt_wait,
    output logic [CNT_W-1:0]              cnt_err,
    output logic                          trc_valid,
    input  logic                          trc_ready,
    output logic [AHB_ADDRESS_WIDTH+11:0] trc_data,
    output logic                          trc_ovf
);

    localparam int         AW       = AHB_ADDRESS_WIDTH;
    localparam int         TW       = AW + 12;
    localparam logic [2:0] MAX_SIZE = 3'($clog2(AHB_DATA_WIDTH / 8));

    localparam logic [0:0] MON_IDLE  = 1'b0;
    localparam logic [0:0] MON_BURST = 1'b1;

    // Burst context
    logic [0:0]    r_state;
    logic          r_write;
    logic [2:0]    r_size;
    logic [2:0]    r_burst;
    logic [4:0]    r_beat;
    logic [4:0]    r_beats;
    logic [AW-1:0] r_exp_addr;
    logic          r_last_done;

    // Address phase held over a wait state
    logic          r_stall_vld;
    logic [AW-1:0] r_stall_addr;
    logic [1:0]    r_stall_trans;
    logic          r_stall_write;

    logic          r_err_valid;
    logic [3:0]    r_err_code;
    logic [AW-1:0] r_err_addr;

    logic [CNT_W-1:0] r_cnt_nonseq;
    logic [CNT_W-1:0] r_cnt_seq;
    logic [CNT_W-1:0] r_cnt_busy;
    logic [CNT_W-1:0] r_cnt_wait;
    logic [CNT_W-1:0] r_cnt_err;

    logic          w_nonseq_acc;
    logic          w_seq_acc;
    logic          w_accept;
    logic          w_in_burst;
    logic          w_fixed;
    logic [2:0]    w_nx_size;
    logic [2:0]    w_nx_burst;
    logic [AW-1:0] w_next_addr;
    logic [AW-1:0] w_align_mask;
    logic [3:0]    w_err_code;
    logic [1:0]    w_err_inc;
    logic [4:0]    w_trc_beat;
    logic [TW-1:0] w_trc_word;
    logic          w_e1, w_e2, w_e3, w_e4, w_e5, w_e6, w_e7, w_e8, w_e9;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] v, input logic [1:0] inc);
        logic [CNT_W:0] s;
        s = {1'b0, v} + (CNT_W+1)'(inc);
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    assign w_nonseq_acc = HREADY && (HTRANS == HTRANS_NONSEQ);
    assign w_seq_acc    = HREADY && (HTRANS == HTRANS_SEQ);
    assign w_accept     = w_nonseq_acc || w_seq_acc;
    assign w_in_burst   = (r_state == MON_BURST);
    assign w_fixed      = (r_beats != 5'd0);

    // A NONSEQ starts from its own control; a SEQ continues the latched burst.
    assign w_nx_size    = w_nonseq_acc ? HSIZE  : r_size;
    assign w_nx_burst   = w_nonseq_acc ? HBURST : r_burst;
    assign w_next_addr  = AW'(next_addr(MAX_AW'(HADDR), w_nx_size, w_nx_burst));
    assign w_align_mask = (AW'(1) << HSIZE) - AW'(1);

    assign w_e1 = HREADY && !w_in_burst &&
                  (((HTRANS == HTRANS_SEQ) && !r_last_done) || (HTRANS == HTRANS_BUSY));
    assign w_e2 = w_seq_acc && w_in_burst && (HADDR != r_exp_addr);
    assign w_e3 = w_seq_acc && w_in_burst &&
                  ((HWRITE != r_write) || (HSIZE != r_size) || (HBURST != r_burst));
    assign w_e4 = HREADY && w_in_burst && w_fixed &&
                  ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_IDLE));
    assign w_e5 = w_seq_acc && !w_in_burst && r_last_done;
    assign w_e6 = w_accept && (HSIZE > MAX_SIZE);
    assign w_e7 = w_accept && ((HADDR & w_align_mask) != '0);
    assign w_e8 = w_seq_acc && w_in_burst && !burst_is_wrap(r_burst) && (HADDR[9:0] == 10'd0);
    assign w_e9 = r_stall_vld &&
                  ((HADDR != r_stall_addr) || (HTRANS != r_stall_trans) || (HWRITE != r_stall_write));

    // Pick the lowest-numbered violation present this cycle.
    always_comb begin
        w_err_code = ERR_NONE;
        if (w_e1)      w_err_code = ERR_OUTSIDE_BURST;
        else if (w_e2) w_err_code = ERR_SEQ_ADDR;
        else if (w_e3) w_err_code = ERR_CTRL_CHANGE;
        else if (w_e4) w_err_code = ERR_EARLY_END;
        else if (w_e5) w_err_code = ERR_PAST_LAST;
        else if (w_e6) w_err_code = ERR_SIZE;
        else if (w_e7) w_err_code = ERR_ALIGN;
        else if (w_e8) w_err_code = ERR_CROSS_1KB;
        else if (w_e9) w_err_code = ERR_STALL_CHANGE;
    end

    assign w_err_inc = {1'b0, (w_err_code != ERR_NONE)} + {1'b0, (HREADY && HRESP)};

    // Burst tracking FSM; advances only on cycles where HREADY completes a phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state     <= MON_IDLE;
            r_write     <= 1'b0;
            r_size      <= 3'd0;
            r_burst     <= 3'd0;
            r_beat      <= 5'd0;
            r_beats     <= 5'd0;
            r_exp_addr  <= '0;
            r_last_done <= 1'b0;
        end else if (HREADY) begin
            r_last_done <= 1'b0;
            case (HTRANS)
                HTRANS_NONSEQ: begin
                    r_write    <= HWRITE;
                    r_size     <= HSIZE;
                    r_burst    <= HBURST;
                    r_beat     <= 5'd1;
                    r_beats    <= burst_beats(HBURST);
                    r_exp_addr <= w_next_addr;
                    r_state    <= (HBURST == HBURST_SINGLE) ? MON_IDLE : MON_BURST;
                end
                HTRANS_SEQ: begin
                    if (w_in_burst) begin
                        r_beat     <= r_beat + 5'd1;
                        r_exp_addr <= w_next_addr;
                        if (w_fixed && (r_beat + 5'd1 == r_beats)) begin
                            r_state     <= MON_IDLE;
                            r_last_done <= 1'b1;
                        end
                    end
                end
                HTRANS_IDLE: r_state <= MON_IDLE;
                default: ;
            endcase
        end
    end

    // Remember a NONSEQ/SEQ address phase stretched by HREADY=0 so the next cycle can compare.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_stall_vld   <= 1'b0;
            r_stall_addr  <= '0;
            r_stall_trans <= 2'd0;
            r_stall_write <= 1'b0;
        end else begin
            r_stall_vld   <= !HREADY && ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
            r_stall_addr  <= HADDR;
            r_stall_trans <= HTRANS;
            r_stall_write <= HWRITE;
        end
    end

    // Registered violation report, one-cycle pulse.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_err_valid <= 1'b0;
            r_err_code  <= 4'd0;
            r_err_addr  <= '0;
        end else begin
            r_err_valid <= (w_err_code != ERR_NONE);
            r_err_code  <= w_err_code;
            r_err_addr  <= (w_err_code != ERR_NONE) ? HADDR : '0;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_cnt_nonseq <= '0;
            r_cnt_seq    <= '0;
            r_cnt_busy   <= '0;
            r_cnt_wait   <= '0;
            r_cnt_err    <= '0;
        end else begin
            r_cnt_nonseq <= sat_add(r_cnt_nonseq, {1'b0, w_nonseq_acc});
            r_cnt_seq    <= sat_add(r_cnt_seq,    {1'b0, w_seq_acc});
            r_cnt_busy   <= sat_add(r_cnt_busy,   {1'b0, (HTRANS == HTRANS_BUSY)});
            r_cnt_wait   <= sat_add(r_cnt_wait,   {1'b0, !HREADY});
            r_cnt_err    <= sat_add(r_cnt_err,    w_err_inc);
        end
    end

    assign err_valid  = r_err_valid;
    assign err_code   = r_err_code;
    assign err_addr   = r_err_addr;
    assign cnt_nonseq = r_cnt_nonseq;
    assign cnt_seq    = r_cnt_seq;
    assign cnt_busy   = r_cnt_busy;
    assign cnt_wait   = r_cnt_wait;
    assign cnt_err    = r_cnt_err;

    // Beat number recorded with the trace entry: 1 for NONSEQ, running count within a burst, 0 for a stray SEQ.
    assign w_trc_beat = w_nonseq_acc ? 5'd1 : (w_in_burst ? r_beat + 5'd1 : 5'd0);
    assign w_trc_word = {HADDR, HWRITE, HSIZE, HBURST, w_trc_beat};

`ifdef AHB_MON_TRACE_EN
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic          w_trc_pop;
    logic [TW-1:0] w_fifo_data;
    logic          r_trc_ovf;

    assign w_trc_pop = !w_fifo_empty && trc_ready;

    ahb_mon_fifo #(
        .DEPTH (TRC_DEPTH),
        .WIDTH (TW)
    ) u_trc_fifo (
        .clk     (HCLK),
        .rst_n   (HRESETn),
        .i_push  (w_accept),
        .i_data  (w_trc_word),
        .i_pop   (w_trc_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Sticky drop flag: an accept arrived while full with no pop to make room.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_trc_ovf <= 1'b0;
        end else if (w_accept && w_fifo_full && !w_trc_pop) begin
            r_trc_ovf <= 1'b1;
        end
    end

    assign trc_valid = !w_fifo_empty;
    assign trc_data  = w_fifo_empty ? '0 : w_fifo_data;
    assign trc_ovf   = r_trc_ovf;
`else
    logic w_unused_trc;

    assign w_unused_trc = ^{trc_ready, w_trc_word, TRC_DEPTH[0]};
    assign trc_valid    = 1'b0;
    assign trc_data     = '0;
    assign trc_ovf      = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_bus_monitor.sv
// tb/tb_ahb_bus_monitor.sv - self-checking bench for ahb_bus_monitor
module tb_ahb_bus_monitor;

    localparam int AW = 32;
    localparam int CW = 8;
    localparam int CMAX = 255;

    localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NS = 2'd2, T_SEQ = 2'd3;
    localparam logic [2:0] B_SINGLE = 3'd0, B_INCR = 3'd1, B_WRAP4 = 3'd2, B_INCR4 = 3'd3,
                           B_INCR8 = 3'd5;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic [AW-1:0] HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [2:0]    HBURST;
    logic          HREADY;
    logic          HRESP;
    logic          trc_ready;
    logic          err_valid;
    logic [3:0]    err_code;
    logic [AW-1:0] err_addr;
    logic [CW-1:0] cnt_nonseq, cnt_seq, cnt_busy, cnt_wait, cnt_err;
    logic          trc_valid;
    logic [AW+11:0] trc_data;
    logic          trc_ovf;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            n_err;
    logic [3:0]    first_code;
    logic [AW-1:0] first_addr;

    ahb_bus_monitor #(
        .AHB_DATA_WIDTH    (64),
        .AHB_ADDRESS_WIDTH (AW),
        .CNT_W             (CW),
        .TRC_DEPTH         (4)
    ) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HWRITE     (HWRITE),
        .HSIZE      (HSIZE),
        .HBURST     (HBURST),
        .HREADY     (HREADY),
        .HRESP      (HRESP),
        .err_valid  (err_valid),
        .err_code   (err_code),
        .err_addr   (err_addr),
        .cnt_nonseq (cnt_nonseq),
        .cnt_seq    (cnt_seq),
        .cnt_busy   (cnt_busy),
        .cnt_wait   (cnt_wait),
        .cnt_err    (cnt_err),
        .trc_valid  (trc_valid),
        .trc_ready  (trc_ready),
        .trc_data   (trc_data),
        .trc_ovf    (trc_ovf)
    );

    always #5 HCLK = ~HCLK;

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // One bus cycle: apply inputs, clock, then record any reported violation.
    task automatic drive(input logic [1:0] t, input logic [AW-1:0] a, input logic w,
                         input logic [2:0] s, input logic [2:0] b, input logic rdy, input logic resp);
        HTRANS = t; HADDR = a; HWRITE = w; HSIZE = s; HBURST = b; HREADY = rdy; HRESP = resp;
        @(posedge HCLK);
        #1;
        if (err_valid === 1'b1) begin
            n_err++;
            if (n_err == 1) begin
                first_code = err_code;
                first_addr = err_addr;
            end
        end
    endtask

    task automatic idle_cycle();
        drive(T_IDLE, '0, 1'b0, 3'd0, B_SINGLE, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        HTRANS = T_IDLE; HADDR = '0; HWRITE = 1'b0; HSIZE = 3'd0; HBURST = 3'd0;
        HREADY = 1'b1; HRESP = 1'b0; trc_ready = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        n_err = 0;
        first_code = '0;
        first_addr = '0;
    endtask

    task automatic test_reset();
        do_reset();
        HRESETn = 1'b0;
        HTRANS = T_NS; HADDR = 32'h102; HSIZE = 3'd4; HREADY = 1'b0; HRESP = 1'b1; trc_ready = 1'b1;
        repeat (3) @(posedge HCLK);
        #1;
        n_tests++;
        if ({err_valid, err_code, err_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_err: got v=%0b code=%0d addr=%h expected all 0", err_valid, err_code, err_addr);
        end
        n_tests++;
        if ({cnt_nonseq, cnt_seq, cnt_busy, cnt_wait, cnt_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d %0d %0d %0d %0d expected 0", cnt_nonseq, cnt_seq, cnt_busy, cnt_wait, cnt_err);
        end
        n_tests++;
        if ({trc_valid, trc_data, trc_ovf} !== '0) begin
            n_fail++;
            $display("FAIL reset_trc: got v=%0b data=%h ovf=%0b expected 0", trc_valid, trc_data, trc_ovf);
        end
    endtask

    task automatic test_incr4();
        do_reset();
        drive(T_NS, 32'h100, 1'b1, 3'd2, B_INCR4, 1'b1, 1'b0);
        for (int i = 1; i < 4; i++) drive(T_SEQ, 32'h100 + 32'(4 * i), 1'b1, 3'd2, B_INCR4, 1'b1, 1'b0);
        idle_cycle();
        n_tests++;
        if (cnt_nonseq !== 8'd1 || cnt_seq !== 8'd3) begin
            n_fail++;
            $display("FAIL incr4_cnt: got nonseq=%0d seq=%0d expected 1 3", cnt_nonseq, cnt_seq);
        end
        n_tests++;
        if (n_err !== 0) begin
            n_fail++;
            $display("FAIL incr4_err: got %0d errors (first code %0d) expected 0", n_err, first_code);
        end
    endtask

    task automatic test_wrap4();
        logic [AW-1:0] seq_a [4];
        seq_a[0] = 32'h38; seq_a[1] = 32'h3C; seq_a[2] = 32'h30; seq_a[3] = 32'h34;
        do_reset();
        for (int i = 0; i < 4; i++)
            drive(i == 0 ? T_NS : T_SEQ, seq_a[i], 1'b0, 3'd2, B_WRAP4, 1'b1, 1'b0);
        idle_cycle();
        n_tests++;
        if (n_err !== 0 || cnt_seq !== 8'd3) begin
            n_fail++;
            $display("FAIL wrap4_ok: got errors=%0d seq=%0d expected 0 3", n_err, cnt_seq);
        end
        n_err = 0;
        drive(T_NS, 32'h38, 1'b0, 3'd2, B_WRAP4, 1'b1, 1'b0);
        drive(T_SEQ, 32'h3C, 1'b0, 3'd2, B_WRAP4, 1'b1, 1'b0);
        drive(T_SEQ, 32'h40, 1'b0, 3'd2, B_WRAP4, 1'b1, 1'b0);
        n_tests++;
        if (n_err !== 1 || first_code !== 4'd2 || first_addr !== 32'h40) begin
            n_fail++;
            $display("FAIL wrap4_bad_addr: got n=%0d code=%0d addr=%h expected 1 2 00000040", n_err, first_code, first_addr);
        end
    endtask

    task automatic test_early_end();
        do_reset();
        drive(T_NS, 32'h200, 1'b0, 3'd2, B_INCR8, 1'b1, 1'b0);
        for (int i = 1; i < 5; i++) drive(T_SEQ, 32'h200 + 32'(4 * i), 1'b0, 3'd2, B_INCR8, 1'b1, 1'b0);
        drive(T_NS, 32'h300, 1'b1, 3'd2, B_INCR4, 1'b1, 1'b0);
        for (int i = 1; i < 4; i++) drive(T_SEQ, 32'h300 + 32'(4 * i), 1'b1, 3'd2, B_INCR4, 1'b1, 1'b0);
        idle_cycle();
        n_tests++;
        if (n_err !== 1 || first_code !== 4'd4 || first_addr !== 32'h300) begin
            n_fail++;
            $display("FAIL early_end: got n=%0d code=%0d addr=%h expected 1 4 00000300", n_err, first_code, first_addr);
        end
        n_tests++;
        if (cnt_nonseq !== 8'd2 || cnt_seq !== 8'd7 || cnt_err !== 8'd1) begin
            n_fail++;
            $display("FAIL early_end_cnt: got ns=%0d seq=%0d err=%0d expected 2 7 1", cnt_nonseq, cnt_seq, cnt_err);
        end
    endtask

    task automatic test_size_align();
        logic [AW-1:0] a_tab [3];
        logic [2:0]    s_tab [3];
        logic [3:0]    c_tab [3];
        a_tab[0] = 32'h100; s_tab[0] = 3'd4; c_tab[0] = 4'd6;
        a_tab[1] = 32'h102; s_tab[1] = 3'd2; c_tab[1] = 4'd7;
        a_tab[2] = 32'h102; s_tab[2] = 3'd4; c_tab[2] = 4'd6;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            n_err = 0;
            drive(T_NS, a_tab[i], 1'b0, s_tab[i], B_SINGLE, 1'b1, 1'b0);
            n_tests++;
            if (n_err !== 1 || first_code !== c_tab[i] || first_addr !== a_tab[i]) begin
                n_fail++;
                $display("FAIL size_align_%0d: got n=%0d code=%0d addr=%h expected 1 %0d %h", i, n_err, first_code, first_addr, c_tab[i], a_tab[i]);
            end
        end
        idle_cycle();
        n_tests++;
        if (cnt_err !== 8'd3) begin
            n_fail++;
            $display("FAIL size_align_cnt_err: got %0d expected 3", cnt_err);
        end
    endtask

    task automatic test_stall();
        do_reset();
        drive(T_NS, 32'h100, 1'b0, 3'd2, B_SINGLE, 1'b0, 1'b0);
        drive(T_NS, 32'h104, 1'b0, 3'd2, B_SINGLE, 1'b0, 1'b0);
        drive(T_NS, 32'h104, 1'b0, 3'd2, B_SINGLE, 1'b0, 1'b0);
        drive(T_NS, 32'h104, 1'b0, 3'd2, B_SINGLE, 1'b1, 1'b0);
        idle_cycle();
        n_tests++;
        if (n_err !== 1 || first_code !== 4'd9 || first_addr !== 32'h104) begin
            n_fail++;
            $display("FAIL stall_change: got n=%0d code=%0d addr=%h expected 1 9 00000104", n_err, first_code, first_addr);
        end
        n_tests++;
        if (cnt_wait !== 8'd3 || cnt_nonseq !== 8'd1) begin
            n_fail++;
            $display("FAIL stall_cnt: got wait=%0d nonseq=%0d expected 3 1", cnt_wait, cnt_nonseq);
        end
    endtask

    task automatic test_misc_codes();
        // Stray SEQ with no burst open
        do_reset();
        drive(T_SEQ, 32'h10, 1'b0, 3'd2, B_INCR, 1'b1, 1'b0);
        n_tests++;
        if (n_err !== 1 || first_code !== 4'd1 || first_addr !== 32'h10) begin
            n_fail++;
            $display("FAIL code1: got n=%0d code=%0d addr=%h expected 1 1 00000010", n_err, first_code, first_addr);
        end
        // SEQ right after the last beat of an INCR4
        do_reset();
        drive(T_NS, 32'h100, 1'b0, 3'd2, B_INCR4, 1'b1, 1'b0);
        for (int i = 1; i < 4; i++) drive(T_SEQ, 32'h100 + 32'(4 * i), 1'b0, 3'd2, B_INCR4, 1'b1, 1'b0);
        drive(T_SEQ, 32'h110, 1'b0, 3'd2, B_INCR4, 1'b1, 1'b0);
        n_tests++;
        if (n_err !== 1 || first_code !== 4'd5 || first_addr !== 32'h110) begin
            n_fail++;
            $display("FAIL code5: got n=%0d code=%0d addr=%h expected 1 5 00000110", n_err, first_code, first_addr);
        end
        // HWRITE flips mid-burst
        do_reset();
        drive(T_NS, 32'h100, 1'b1, 3'd2, B_INCR4, 1'b1, 1'b0);
        drive(T_SEQ, 32'h104, 1'b0, 3'd2, B_INCR4, 1'b1, 1'b0);
        n_tests++;
        if (n_err !== 1 || first_code !== 4'd3 || first_addr !== 32'h104) begin
            n_fail++;
            $display("FAIL code3: got n=%0d code=%0d addr=%h expected 1 3 00000104", n_err, first_code, first_addr);
        end
        // INCR running over a 1KB boundary
        do_reset();
        drive(T_NS, 32'h3FC, 1'b0, 3'd2, B_INCR, 1'b1, 1'b0);
        drive(T_SEQ, 32'h400, 1'b0, 3'd2, B_INCR, 1'b1, 1'b0);
        n_tests++;
        if (n_err !== 1 || first_code !== 4'd8 || first_addr !== 32'h400) begin
            n_fail++;
            $display("FAIL code8: got n=%0d code=%0d addr=%h expected 1 8 00000400", n_err, first_code, first_addr);
        end
        // Slave ERROR response counts without a violation pulse
        do_reset();
        drive(T_IDLE, '0, 1'b0, 3'd0, B_SINGLE, 1'b1, 1'b1);
        idle_cycle();
        n_tests++;
        if (n_err !== 0 || cnt_err !== 8'd1) begin
            n_fail++;
            $display("FAIL hresp: got n=%0d cnt_err=%0d expected 0 1", n_err, cnt_err);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 300; i++) drive(T_NS, 32'h0, 1'b0, 3'd0, B_SINGLE, 1'b1, 1'b0);
        idle_cycle();
        n_tests++;
        if (cnt_nonseq !== 8'hFF || n_err !== 0) begin
            n_fail++;
            $display("FAIL saturation: got cnt_nonseq=%0d errors=%0d expected 255 0", cnt_nonseq, n_err);
        end
    endtask

    // Random legal traffic; expected counts come from what the bench itself issued.
    task automatic test_random();
        int m_ns, m_seq, m_busy, m_wait, m_err;
        int unsigned bytes, len, region, start, bound, blk, a;
        logic [2:0] b, s;
        logic w, wrap;
        int waits, gaps;
        m_ns = 0; m_seq = 0; m_busy = 0; m_wait = 0; m_err = 0;
        do_reset();
        for (int n = 0; n < 30; n++) begin
            b     = 3'($urandom_range(0, 7));
            s     = 3'($urandom_range(0, 3));
            w     = 1'($urandom_range(0, 1));
            bytes = 1 << s;
            wrap  = (b == 3'd2) || (b == 3'd4) || (b == 3'd6);
            case (b)
                3'd0:       len = 1;
                3'd1:       len = $urandom_range(1, 6);
                3'd2, 3'd3: len = 4;
                3'd4, 3'd5: len = 8;
                default:    len = 16;
            endcase
            region = $urandom_range(0, 15) * 1024;
            bound  = len * bytes;
            if (wrap) start = region + $urandom_range(0, 1024 / bytes - 1) * bytes;
            else      start = region + $urandom_range(0, (1024 - len * bytes) / bytes) * bytes;
            blk = start - (start % bound);
            for (int i = 0; i < int'(len); i++) begin
                a = wrap ? blk + ((start - blk + i * bytes) % bound) : start + i * bytes;
                if (i > 0 && $urandom_range(0, 3) == 0) begin
                    drive(T_BUSY, a, w, s, b, 1'b1, 1'b0);
                    m_busy++;
                end
                waits = $urandom_range(0, 2);
                for (int k = 0; k < waits; k++) drive(i == 0 ? T_NS : T_SEQ, a, w, s, b, 1'b0, 1'b0);
                m_wait += waits;
                drive(i == 0 ? T_NS : T_SEQ, a, w, s, b, 1'b1, 1'b0);
                if (i == 0) m_ns++; else m_seq++;
            end
            gaps = $urandom_range(0, 2);
            for (int k = 0; k < gaps; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    drive(T_IDLE, '0, 1'b0, 3'd0, B_SINGLE, 1'b1, 1'b1);
                    m_err++;
                end else begin
                    idle_cycle();
                end
            end
        end
        idle_cycle();
        n_tests++;
        if (n_err !== 0) begin
            n_fail++;
            $display("FAIL random_no_err: got %0d violations (first code %0d addr %h) expected 0", n_err, first_code, first_addr);
        end
        n_tests++;
        if (int'(cnt_nonseq) != sat(m_ns) || int'(cnt_seq) != sat(m_seq)) begin
            n_fail++;
            $display("FAIL random_xfer_cnt: got ns=%0d seq=%0d expected %0d %0d", cnt_nonseq, cnt_seq, sat(m_ns), sat(m_seq));
        end
        n_tests++;
        if (int'(cnt_busy) != sat(m_busy) || int'(cnt_wait) != sat(m_wait) || int'(cnt_err) != sat(m_err)) begin
            n_fail++;
            $display("FAIL random_other_cnt: got busy=%0d wait=%0d err=%0d expected %0d %0d %0d",
                     cnt_busy, cnt_wait, cnt_err, sat(m_busy), sat(m_wait), sat(m_err));
        end
    endtask

    task automatic test_trace();
        logic [AW+11:0] exp_d;
        logic [AW-1:0]  ea;
        logic           ew;
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            ea = 32'(i * 16);
            ew = i[0];
            drive(T_NS, ea, ew, 3'd2, B_SINGLE, 1'b1, 1'b0);
        end
        idle_cycle();
`ifdef AHB_MON_TRACE_EN
        n_tests++;
        if (trc_valid !== 1'b1 || trc_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL trace_full: got valid=%0b ovf=%0b expected 1 1", trc_valid, trc_ovf);
        end
        for (int i = 1; i <= 4; i++) begin
            ea = 32'(i * 16);
            ew = i[0];
            exp_d = {ea, ew, 3'd2, B_SINGLE, 5'd1};
            n_tests++;
            if (trc_valid !== 1'b1 || trc_data !== exp_d) begin
                n_fail++;
                $display("FAIL trace_pop_%0d: got valid=%0b data=%h expected 1 %h", i, trc_valid, trc_data, exp_d);
            end
            trc_ready = 1'b1;
            idle_cycle();
            trc_ready = 1'b0;
        end
        n_tests++;
        if (trc_valid !== 1'b0 || trc_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL trace_drained: got valid=%0b ovf=%0b expected 0 1", trc_valid, trc_ovf);
        end
`else
        exp_d = '0;
        trc_ready = 1'b1;
        idle_cycle();
        n_tests++;
        if (trc_valid !== 1'b0 || trc_data !== exp_d || trc_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL trace_off: got valid=%0b data=%h ovf=%0b expected 0 0 0", trc_valid, trc_data, trc_ovf);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_incr4();
        test_wrap4();
        test_early_end();
        test_size_align();
        test_stall();
        test_misc_codes();
        test_saturation();
        test_random();
        test_trace();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
